// File: rtl/kmer_query_responder_pkg.sv
// Shared FSM encoding and hash constants for the k-mer Bloom-filter query responder.
package kmer_query_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_INSERT  = 3'd2,
        ST_PROBE   = 3'd3,
        ST_RESPOND = 3'd4
    } state_t;

    localparam int unsigned HASH_ROT   = 32'd5;
    localparam logic [11:0] HASH_CONST = 12'h9E3;

endpackage

// File: rtl/kmer_query_responder_ram.sv
// Single-port 1-bit Bloom-filter table with a registered read port.
module bloomBitRam #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_wdata,
    output logic              o_rdata
);

    logic r_mem [0:(1<<ADDR_W)-1];
    logic r_rdata;

    // Table write port; contents are only ever initialised by a CLEAR sweep
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // One-cycle registered read of the addressed bit
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_rdata <= 1'b0;
        end else begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/kmer_query_responder.sv
// Bloom-filter k-mer membership responder: clear sweep, multi-hash insert and fixed-latency probe.
module kmer_query_responder
    import kmer_query_responder_pkg::*;
#(
    parameter int MAX_KMER_BIT_WIDTH = 6,
    parameter int MAX_KMER_WIDTH     = 2**MAX_KMER_BIT_WIDTH,
    parameter int TABLE_BIT_WIDTH    = 12,
    parameter int NUM_HASHES         = 3
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic [2*MAX_KMER_WIDTH-1:0]   kmer,
    input  logic                          kmerValid,
    output logic                          ready4Kmer,
    input  logic [MAX_KMER_BIT_WIDTH-1:0] kmerLength,
    output logic                          queryResultValid,
    output logic                          queryResult,
    input  logic [2*MAX_KMER_WIDTH-1:0]   progKmer,
    input  logic                          progValid,
    output logic                          progReady,
    input  logic                          clearStart,
    output logic                          busy
);

    localparam int KW  = 2*MAX_KMER_WIDTH;
    localparam int NSL = (KW + TABLE_BIT_WIDTH - 1) / TABLE_BIT_WIDTH;

    state_t                     r_state;
    state_t                     w_next;
    logic [TABLE_BIT_WIDTH-1:0] r_addr;
    logic [2:0]                 r_idx;
    logic [KW-1:0]              r_kmer;
    logic                       r_acc;
    logic                       r_clr_pend;
    logic                       r_qvalid;
    logic                       r_qresult;
    logic                       w_clr_req;
    logic                       w_we;
    logic                       w_wdata;
    logic [TABLE_BIT_WIDTH-1:0] w_addr;
    logic                       w_rdata;

    function automatic logic [KW-1:0] f_mask(input logic [KW-1:0] d,
                                             input logic [MAX_KMER_BIT_WIDTH-1:0] len);
        logic [KW-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_KMER_WIDTH; b++) begin
            if (b < int'(len)) begin
                m[2*b +: 2] = d[2*b +: 2];
            end else begin
                m[2*b +: 2] = 2'b00;
            end
        end
        return m;
    endfunction

    // Rotate left by 5*idx, fold into table-width slices (top slice zero-padded), salt with idx*const
    function automatic logic [TABLE_BIT_WIDTH-1:0] f_hash(input logic [KW-1:0] d,
                                                          input logic [2:0] idx);
        logic [KW-1:0]                  rot;
        logic [NSL*TABLE_BIT_WIDTH-1:0] pad;
        logic [TABLE_BIT_WIDTH-1:0]     acc;
        logic [31:0]                    sh;
        sh  = 32'(idx) * HASH_ROT;
        rot = (d << sh) | (d >> (32'(KW) - sh));
        pad = '0;
        pad[KW-1:0] = rot;
        acc = TABLE_BIT_WIDTH'(32'(idx) * 32'(HASH_CONST));
        for (int s = 0; s < NSL; s++) begin
            acc = acc ^ pad[s*TABLE_BIT_WIDTH +: TABLE_BIT_WIDTH];
        end
        return acc;
    endfunction

    assign w_clr_req        = clearStart | r_clr_pend;
    assign ready4Kmer       = (r_state == ST_IDLE) & ~w_clr_req & ~progValid;
    assign progReady        = (r_state == ST_IDLE) & ~w_clr_req;
    assign busy             = (r_state != ST_IDLE);
    assign queryResultValid = r_qvalid;
    assign queryResult      = r_qresult;

    // Next-state selection and RAM port control
    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_wdata = 1'b0;
        w_addr  = f_hash(r_kmer, r_idx);
        case (r_state)
            ST_IDLE: begin
                if (w_clr_req) begin
                    w_next = ST_CLEAR;
                end else if (progValid) begin
                    w_next = ST_INSERT;
                end else if (kmerValid) begin
                    w_next = ST_PROBE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_we   = 1'b1;
                w_addr = r_addr;
                if (clearStart) begin
                    w_next = ST_CLEAR;
                end else if (r_addr == '1) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_CLEAR;
                end
            end
            ST_INSERT: begin
                w_we    = 1'b1;
                w_wdata = 1'b1;
                if (r_idx == 3'(NUM_HASHES-1)) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_INSERT;
                end
            end
            ST_PROBE: begin
                if (r_idx == 3'(NUM_HASHES-1)) begin
                    w_next = ST_RESPOND;
                end else begin
                    w_next = ST_PROBE;
                end
            end
            ST_RESPOND: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // State, request latching, AND-accumulation of probe bits and result strobe
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state    <= ST_CLEAR;
            r_addr     <= '0;
            r_idx      <= 3'd0;
            r_kmer     <= '0;
            r_acc      <= 1'b0;
            r_clr_pend <= 1'b0;
            r_qvalid   <= 1'b0;
            r_qresult  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_qvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_idx  <= 3'd0;
                    r_addr <= '0;
                    r_acc  <= 1'b1;
                    if (w_clr_req) begin
                        r_clr_pend <= 1'b0;
                    end else if (progValid) begin
                        r_kmer <= f_mask(progKmer, kmerLength);
                    end else if (kmerValid) begin
                        r_kmer <= f_mask(kmer, kmerLength);
                    end
                end
                ST_CLEAR: begin
                    r_addr <= clearStart ? '0 : r_addr + TABLE_BIT_WIDTH'(1);
                end
                ST_INSERT: begin
                    r_idx <= r_idx + 3'd1;
                    if (clearStart) r_clr_pend <= 1'b1;
                end
                ST_PROBE: begin
                    r_idx <= r_idx + 3'd1;
                    // read data lags the issued address by one cycle
                    if (r_idx != 3'd0) r_acc <= r_acc & w_rdata;
                    if (clearStart) r_clr_pend <= 1'b1;
                end
                ST_RESPOND: begin
                    r_qvalid  <= 1'b1;
                    r_qresult <= r_acc & w_rdata;
                    if (clearStart) r_clr_pend <= 1'b1;
                end
                default: begin
                    r_idx <= 3'd0;
                end
            endcase
        end
    end

    bloomBitRam #(
        .ADDR_W (TABLE_BIT_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rstb    (rstb),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_kmer_query_responder.sv
// Directed bench for kmer_query_responder: vector table of inserts/queries plus multi-cycle corner sequences.
module tb_kmer_query_responder;

    logic         clk = 1'b0;
    logic         rstb;
    logic [127:0] kmer;
    logic         kmerValid;
    logic         ready4Kmer;
    logic [5:0]   kmerLength;
    logic         queryResultValid;
    logic         queryResult;
    logic [127:0] progKmer;
    logic         progValid;
    logic         progReady;
    logic         clearStart;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit           is_ins;
        logic [127:0] k;
        logic [5:0]   len;
        bit           exp;
    } vec_t;
    vec_t vecs [16];

    localparam logic [127:0] KA  = 128'h0000_0000_0000_0000_0123_4567_89AB_CDEF;
    localparam logic [127:0] KB  = 128'hCAFE_BABE_0000_0000_0000_00A5_5A3C_C3F0;
    localparam logic [127:0] KB2 = 128'h1234_5678_9ABC_DEF0_1357_9BA5_5A3C_C3F0;
    localparam logic [127:0] KP  = 128'h0000_0000_0000_0000_0F0F_0F0F_0F0F_0F0F;

    int     cnt, pe, qe, re, fe, na, nr;
    logic   rv, p, q, a, seen;
    int     acc_e [4];
    int     res_e [4];
    logic   res_v [4];
    logic [127:0] seqk [4];
    logic   seqx [4];

    always #5 clk = ~clk;

    kmer_query_responder dut (
        .clk              (clk),
        .rstb             (rstb),
        .kmer             (kmer),
        .kmerValid        (kmerValid),
        .ready4Kmer       (ready4Kmer),
        .kmerLength       (kmerLength),
        .queryResultValid (queryResultValid),
        .queryResult      (queryResult),
        .progKmer         (progKmer),
        .progValid        (progValid),
        .progReady        (progReady),
        .clearStart       (clearStart),
        .busy             (busy)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_qready(input string nm);
        int w = 0;
        #1;
        while (!ready4Kmer && w < 50) begin
            @(negedge clk); #1; w++;
        end
        check(nm, 32'(ready4Kmer), 32'd1);
    endtask

    task automatic do_insert(input logic [127:0] k, input logic [5:0] len, input string nm);
        int w = 0;
        @(negedge clk);
        progKmer = k; kmerLength = len; progValid = 1'b1;
        #1;
        while (!progReady && w < 50) begin
            @(negedge clk); #1; w++;
        end
        check({nm, "_prdy"}, 32'(progReady), 32'd1);
        @(posedge clk); #1;
        progValid = 1'b0; progKmer = ~k; kmerLength = ~len;
    endtask

    task automatic do_query(input logic [127:0] k, input logic [5:0] len, input bit exp, input string nm);
        int   lat;
        logic got;
        @(negedge clk);
        kmer = k; kmerLength = len; kmerValid = 1'b1;
        wait_qready({nm, "_rdy"});
        @(posedge clk); #1;
        kmerValid = 1'b0; kmer = ~k; kmerLength = ~len;
        lat = 0; got = 1'b0;
        for (int e = 1; e <= 10 && lat == 0; e++) begin
            @(posedge clk); #1;
            if (queryResultValid) begin lat = e; got = queryResult; end
        end
        check({nm, "_lat"}, 32'(lat), 32'd4);
        check({nm, "_res"}, 32'(got), 32'(exp));
        @(posedge clk); #1;
        check({nm, "_strobe"}, 32'(queryResultValid), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, KA,       6'd32, 1'b0};
        vecs[1]  = '{1'b0, KA,       6'd32, 1'b1};
        vecs[2]  = '{1'b0, {64'hFFFF_0000_1234_5678, KA[63:0]}, 6'd32, 1'b1};
        vecs[3]  = '{1'b0, KA,       6'd16, 1'b0};
        vecs[4]  = '{1'b1, KB,       6'd20, 1'b0};
        vecs[5]  = '{1'b0, KB2,      6'd20, 1'b1};
        vecs[6]  = '{1'b0, KB2,      6'd24, 1'b0};
        vecs[7]  = '{1'b0, 128'h1,   6'd1,  1'b0};
        vecs[8]  = '{1'b0, '1,       6'd0,  1'b0};
        vecs[9]  = '{1'b1, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 6'd0, 1'b0};
        vecs[10] = '{1'b0, 128'h0,   6'd5,  1'b1};
        vecs[11] = '{1'b0, 128'h1,   6'd1,  1'b0};
        vecs[12] = '{1'b1, '1,       6'd63, 1'b0};
        vecs[13] = '{1'b0, '1,       6'd63, 1'b1};
        vecs[14] = '{1'b0, '1,       6'd62, 1'b0};
        vecs[15] = '{1'b0, 128'h0,   6'd31, 1'b1};

        rstb = 1'b0; kmer = '0; kmerValid = 1'b0; kmerLength = '0;
        progKmer = '0; progValid = 1'b0; clearStart = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rdy", 32'(ready4Kmer), 32'd0);
        check("rst_prdy", 32'(progReady), 32'd0);
        check("rst_qv", 32'(queryResultValid), 32'd0);
        check("rst_qr", 32'(queryResult), 32'd0);
        @(negedge clk); rstb = 1'b1;
        cnt = 0;
        for (int c = 1; c <= 5000; c++) begin
            @(posedge clk); #1;
            if (!busy) begin cnt = c; break; end
        end
        check("init_clear_cycles", 32'(cnt), 32'd4096);
        check("init_rdy", 32'(ready4Kmer), 32'd1);
        do_query(128'h0, 6'd31, 1'b0, "empty_q");

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_ins) do_insert(vecs[i].k, vecs[i].len, $sformatf("vec%0d", i));
            else                do_query(vecs[i].k, vecs[i].len, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // back-to-back queries with kmerValid held high
        seqk[0] = KA; seqk[1] = 128'h1; seqk[2] = KA; seqk[3] = 128'h2;
        seqx[0] = 1'b1; seqx[1] = 1'b0; seqx[2] = 1'b1; seqx[3] = 1'b0;
        na = 0; nr = 0;
        @(negedge clk);
        kmer = seqk[0]; kmerLength = 6'd32; kmerValid = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            #1; a = ready4Kmer;
            @(posedge clk); #1;
            if (queryResultValid && nr < 4) begin res_e[nr] = e; res_v[nr] = queryResult; nr++; end
            if (a && na < 4) begin
                acc_e[na] = e; na++;
                if (na < 4) kmer = seqk[na]; else kmerValid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_accepts", 32'(na), 32'd4);
        check("b2b_results", 32'(nr), 32'd4);
        if (na == 4 && nr == 4) begin
            for (int i = 0; i < 4; i++) begin
                if (i > 0) check($sformatf("b2b_gap%0d", i), 32'(acc_e[i] - acc_e[i-1]), 32'd5);
                check($sformatf("b2b_lat%0d", i), 32'(res_e[i] - acc_e[i]), 32'd4);
                check($sformatf("b2b_res%0d", i), 32'(res_v[i]), 32'(seqx[i]));
            end
        end

        // clearStart, progValid and kmerValid all together in IDLE
        @(negedge clk);
        clearStart = 1'b1; progValid = 1'b1; progKmer = KP;
        kmerValid = 1'b1; kmer = KA; kmerLength = 6'd32;
        #1;
        check("prio_rdy", 32'(ready4Kmer), 32'd0);
        check("prio_prdy", 32'(progReady), 32'd0);
        @(posedge clk); #1; clearStart = 1'b0;
        pe = -1; qe = -1; re = -1; rv = 1'b1;
        for (int e = 1; e <= 4300 && re < 0; e++) begin
            @(negedge clk); #1;
            p = progValid & progReady;
            q = kmerValid & ready4Kmer;
            @(posedge clk); #1;
            if (p) begin pe = e; progValid = 1'b0; end
            if (q) begin qe = e; kmerValid = 1'b0; end
            if (queryResultValid) begin re = e; rv = queryResult; end
        end
        progValid = 1'b0; kmerValid = 1'b0;
        check("prio_ins_edge", 32'(pe), 32'd4097);
        check("prio_qry_edge", 32'(qe), 32'd4101);
        check("prio_res_edge", 32'(re), 32'd4105);
        check("prio_res", 32'(rv), 32'd0);
        do_query(KP, 6'd32, 1'b1, "post_clr_P");

        // clearStart during PROBE is held until the next IDLE
        @(negedge clk);
        kmer = KP; kmerLength = 6'd32; kmerValid = 1'b1;
        wait_qready("pend_rdy");
        @(posedge clk); #1; kmerValid = 1'b0;
        re = -1; fe = -1; rv = 1'b0;
        for (int e = 1; e <= 4300 && fe < 0; e++) begin
            if (e == 2) clearStart = 1'b1;
            @(posedge clk); #1;
            clearStart = 1'b0;
            if (queryResultValid) begin re = e; rv = queryResult; end
            if (ready4Kmer) fe = e;
        end
        check("pend_res_edge", 32'(re), 32'd4);
        check("pend_res", 32'(rv), 32'd1);
        check("pend_ready_edge", 32'(fe), 32'd4101);
        do_query(KP, 6'd32, 1'b0, "post_pend_P");

        // clearStart during CLEAR restarts the sweep
        @(negedge clk);
        clearStart = 1'b1;
        #1;
        check("restart_prdy", 32'(progReady), 32'd0);
        @(posedge clk); #1; clearStart = 1'b0;
        fe = -1;
        for (int e = 1; e <= 4400 && fe < 0; e++) begin
            if (e == 100) clearStart = 1'b1;
            @(posedge clk); #1;
            clearStart = 1'b0;
            if (!busy) fe = e;
        end
        check("restart_done_edge", 32'(fe), 32'd4196);

        // reset two cycles into PROBE
        do_insert(KP, 6'd32, "rstp_ins");
        @(negedge clk);
        kmer = KP; kmerLength = 6'd32; kmerValid = 1'b1;
        wait_qready("rstp_rdy");
        @(posedge clk); #1; kmerValid = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen = seen | queryResultValid;
        end
        rstb = 1'b0;
        #1;
        check("rstp_busy", 32'(busy), 32'd1);
        check("rstp_rdy0", 32'(ready4Kmer), 32'd0);
        check("rstp_qv0", 32'(queryResultValid), 32'd0);
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        cnt = 0;
        for (int c = 1; c <= 5000; c++) begin
            @(posedge clk); #1;
            seen = seen | queryResultValid;
            if (!busy) begin cnt = c; break; end
        end
        check("rstp_no_strobe", 32'(seen), 32'd0);
        check("rstp_clear_cycles", 32'(cnt), 32'd4096);
        do_query(KP, 6'd32, 1'b0, "post_rst_P");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
